mult_div_unit: RTL and testbench



---
 rtl/mult_div_unit.sv | 173 +++++++++++++++++
 tb/tb_mult_div_unit.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Multiplies use a shift-add over a 2*XLEN accumulator and divides use
// restoring shift-subtract. Both run on operand magnitudes, and the sign
// is fixed up in a final cycle before HI/LO are written.
module mult_div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            start,
  input  logic [1:0]      OP,
  input  logic [XLEN-1:0] In1,
  input  logic [XLEN-1:0] In2,
  input  logic            hi_we,
  input  logic            lo_we,
  input  logic [XLEN-1:0] wdata,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t                state_reg, state_next;
  logic [CW-1:0]         count_reg, count_next;
  logic                  div_reg, div_next;           // 1: divide, 0: multiply
  logic [XLEN-1:0]       operand_reg, operand_next;   // multiplicand or divisor magnitude
  logic [2*XLEN-1:0]     acc_reg, acc_next;           // {upper/remainder, lower/quotient}
  logic                  neg_res_reg, neg_res_next;   // product or quotient must be negated
  logic                  neg_rem_reg, neg_rem_next;   // remainder must be negated
  logic                  div_zero_reg, div_zero_next;
  logic [XLEN-1:0]       hi_reg, hi_next;
  logic [XLEN-1:0]       lo_reg, lo_next;
  logic                  done_reg, done_next;

  logic                  start_signed;
  logic                  in1_neg, in2_neg;
  logic [XLEN-1:0]       in1_mag, in2_mag;
  logic [XLEN:0]         mul_sum;
  logic [2*XLEN-1:0]     mul_step;
  logic [XLEN:0]         div_shift;
  logic [XLEN:0]         div_diff;
  logic                  div_ok;
  logic [2*XLEN-1:0]     div_step;
  logic [2*XLEN-1:0]     prod_signed;
  logic [XLEN-1:0]       quot_signed;
  logic [XLEN-1:0]       rem_signed;

  // Operand magnitudes and sign capture at launch; OP[0]=0 marks the signed ops.
  assign start_signed = ~OP[0];
  assign in1_neg      = start_signed & In1[XLEN-1];
  assign in2_neg      = start_signed & In2[XLEN-1];
  assign in1_mag      = in1_neg ? -In1 : In1;
  assign in2_mag      = in2_neg ? -In2 : In2;

  // One shift-add step: add multiplicand to the upper half when the current
  // multiplier bit (acc bit 0) is set, then shift the whole accumulator right.
  assign mul_sum  = {1'b0, acc_reg[2*XLEN-1:XLEN]} +
                    (acc_reg[0] ? {1'b0, operand_reg} : {(XLEN+1){1'b0}});
  assign mul_step = {mul_sum, acc_reg[XLEN-1:1]};

  // One restoring divide step: bring the next dividend bit into the partial
  // remainder and subtract the divisor only if it fits.
  assign div_shift = {acc_reg[2*XLEN-1:XLEN], acc_reg[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, operand_reg};
  assign div_ok    = (div_shift >= {1'b0, operand_reg});
  assign div_step  = div_ok ? {div_diff[XLEN-1:0],  acc_reg[XLEN-2:0], 1'b1}
                            : {div_shift[XLEN-1:0], acc_reg[XLEN-2:0], 1'b0};

  // Final sign fix-up of the magnitude results.
  assign prod_signed = neg_res_reg ? -acc_reg : acc_reg;
  assign quot_signed = neg_res_reg ? -acc_reg[XLEN-1:0] : acc_reg[XLEN-1:0];
  assign rem_signed  = neg_rem_reg ? -acc_reg[2*XLEN-1:XLEN] : acc_reg[2*XLEN-1:XLEN];

  assign busy = (state_reg != IDLE);
  assign done = done_reg;
  assign hi   = hi_reg;
  assign lo   = lo_reg;

  // Next-state and datapath updates for IDLE launch / CALC iterate / FIN write-back.
  always_comb begin
    state_next    = state_reg;
    count_next    = count_reg;
    div_next      = div_reg;
    operand_next  = operand_reg;
    acc_next      = acc_reg;
    neg_res_next  = neg_res_reg;
    neg_rem_next  = neg_rem_reg;
    div_zero_next = div_zero_reg;
    hi_next       = hi_reg;
    lo_next       = lo_reg;
    done_next     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          // start wins over a simultaneous mthi/mtlo write
          div_next      = OP[1];
          neg_res_next  = in1_neg ^ in2_neg;
          neg_rem_next  = in1_neg;
          div_zero_next = OP[1] & (In2 == {XLEN{1'b0}});
          count_next    = CW'(XLEN);
          state_next    = CALC;
          if (OP[1]) begin
            acc_next     = {{XLEN{1'b0}}, in1_mag};
            operand_next = in2_mag;
          end else begin
            acc_next     = {{XLEN{1'b0}}, in2_mag};
            operand_next = in1_mag;
          end
        end else begin
          if (hi_we) hi_next = wdata;
          if (lo_we) lo_next = wdata;
        end
      end
      CALC: begin
        acc_next   = div_reg ? div_step : mul_step;
        count_next = count_reg - CW'(1);
        if (count_reg == CW'(1)) state_next = FIN;
      end
      FIN: begin
        if (div_reg) begin
          // a zero divisor leaves the dividend magnitude in the remainder,
          // which sign-corrects back to the original dividend
          lo_next = div_zero_reg ? {XLEN{1'b1}} : quot_signed;
          hi_next = rem_signed;
        end else begin
          hi_next = prod_signed[2*XLEN-1:XLEN];
          lo_next = prod_signed[XLEN-1:0];
        end
        done_next  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  // Datapath and HI/LO registers; reset discards any operation in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_reg    <= '0;
      div_reg      <= 1'b0;
      operand_reg  <= '0;
      acc_reg      <= '0;
      neg_res_reg  <= 1'b0;
      neg_rem_reg  <= 1'b0;
      div_zero_reg <= 1'b0;
      hi_reg       <= '0;
      lo_reg       <= '0;
      done_reg     <= 1'b0;
    end else begin
      count_reg    <= count_next;
      div_reg      <= div_next;
      operand_reg  <= operand_next;
      acc_reg      <= acc_next;
      neg_res_reg  <= neg_res_next;
      neg_rem_reg  <= neg_rem_next;
      div_zero_reg <= div_zero_next;
      hi_reg       <= hi_next;
      lo_reg       <= lo_next;
      done_reg     <= done_next;
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases plus randomized
// operations compared against a plain-arithmetic HI/LO reference model.
module tb_mult_div_unit;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] in1 = '0;
  logic [31:0] in2 = '0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic [31:0] wdata = '0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int check_count = 0;
  int pass_count  = 0;

  always #5 clock = ~clock;

  mult_div_unit #(.XLEN(32)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .start  (start),
    .OP     (op),
    .In1    (in1),
    .In2    (in2),
    .hi_we  (hi_we),
    .lo_we  (lo_we),
    .wdata  (wdata),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    check_count++;
    if (got === exp) pass_count++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference: returns {hi, lo} computed with 64-bit arithmetic.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, sq, sr;
    logic [63:0] ua, ub, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (o)
      2'd0: begin sq = sa * sb; return sq; end
      2'd1: begin ur = ua * ub; return ur; end
      2'd2: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        sq = sa / sb;
        sr = sa % sb;
        return {sr[31:0], sq[31:0]};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {32'(ua % ub), 32'(ua / ub)};
      end
    endcase
  endfunction

  // Drive a start for one edge; returns #1 after the sampling edge.
  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o; in1 = a; in2 = b; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  // Poll until done; lat counts samples with the one after the start edge as 1.
  task automatic wait_done(output int lat, output int busy_cycles);
    int n;
    busy_cycles = busy ? 1 : 0;
    lat = 0;
    for (n = 1; n <= 100; n++) begin
      @(posedge clock); #1;
      if (busy) busy_cycles++;
      if (done) break;
    end
    lat = n + 1;
    if (n > 100) check("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp, input bit tail);
    int lat, bc;
    launch(o, a, b);
    check({tag, "_busy_up"}, 64'(busy), 64'd1);
    check({tag, "_done_low"}, 64'(done), 64'd0);
    wait_done(lat, bc);
    check({tag, "_latency"}, 64'(lat), 64'd34);
    check({tag, "_busy_cycles"}, 64'(bc), 64'd33);
    check({tag, "_hilo"}, {hi, lo}, exp);
    $display("%s op=%0d a=%h b=%h -> hi=%h lo=%h lat=%0d", tag, o, a, b, hi, lo, lat);
    if (tail) begin
      @(posedge clock); #1;
      check({tag, "_done_once"}, 64'(done), 64'd0);
      check({tag, "_hold"}, {hi, lo}, exp);
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int lat, bc;
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    logic [63:0] exp;

    #12;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);
    reset_n = 1'b1;
    @(posedge clock); #1;

    run_op("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'h0000_0001}, 1'b1);
    run_op("mult_neg",  2'd0, 32'hFFFF_FFFD, 32'd5, {32'hFFFF_FFFF, 32'hFFFF_FFF1}, 1'b0);
    run_op("divu_b2b",  2'd3, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b1);
    run_op("div_neg",   2'd2, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b1);
    run_op("div_ovf",   2'd2, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 1'b1);
    run_op("divu_zero", 2'd3, 32'd100, 32'd0, {32'h0000_0064, 32'hFFFF_FFFF}, 1'b1);
    run_op("div_zero",  2'd2, 32'hFFFF_FFF9, 32'd0, {32'hFFFF_FFF9, 32'hFFFF_FFFF}, 1'b1);

    // start and mthi while busy must both be ignored
    launch(2'd1, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (5) @(posedge clock);
    #1;
    start = 1'b1; op = 2'd2; in1 = 32'd77; in2 = 32'd3; hi_we = 1'b1; wdata = 32'h1234;
    @(posedge clock); #1;
    start = 1'b0; hi_we = 1'b0;
    wait_done(lat, bc);
    check("busy_ignore_hilo", {hi, lo}, model(2'd1, 32'h1234_5678, 32'h9ABC_DEF0));
    $display("busy_ignore hi=%h lo=%h", hi, lo);
    @(posedge clock); #1;

    // mthi/mtlo together in IDLE
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hCAFE_F00D;
    @(posedge clock); #1;
    hi_we = 1'b0; lo_we = 1'b0;
    check("mthilo_value", {hi, lo}, {32'hCAFE_F00D, 32'hCAFE_F00D});
    check("mthilo_no_done", 64'(done), 64'd0);
    check("mthilo_no_busy", 64'(busy), 64'd0);
    @(posedge clock); #1;
    check("mthilo_no_done2", 64'(done), 64'd0);
    $display("mthi_mtlo hi=%h lo=%h", hi, lo);

    // asynchronous reset in the middle of a multiply
    launch(2'd0, 32'h0000_1234, 32'h0000_5678);
    repeat (9) @(posedge clock);
    #2;
    check("pre_reset_busy", 64'(busy), 64'd1);
    reset_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_hilo", {hi, lo}, 64'd0);
    #4;
    reset_n = 1'b1;
    @(posedge clock); #1;
    check("post_reset_idle", 64'(busy), 64'd0);
    check("post_reset_hilo", {hi, lo}, 64'd0);
    $display("reset_abort busy=%0d hi=%h lo=%h", busy, hi, lo);
    run_op("after_reset", 2'd0, 32'h0000_1234, 32'hFFFF_FFF0, model(2'd0, 32'h0000_1234, 32'hFFFF_FFF0), 1'b1);

    // randomized operations against the reference model
    for (int i = 0; i < 40; i++) begin
      ro  = 2'($urandom_range(0, 3));
      ra  = pick();
      rb  = pick();
      exp = model(ro, ra, rb);
      run_op("rand", ro, ra, rb, exp, (i % 4) == 3);
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
